sram_ctrl: RTL

- Synchronous controller that sequences the 128K x 16 asynchronous data SRAM (active-low CS1/OE/WE/LB/UB, active-high CS2, 17-bit word address, 16-bit bidirectional IO) for the RISC-V core's load/store unit.
- Accepts one byte, halfword or word request at a time using a valid/ready handshake.
- Splits word accesses into two 16-bit SRAM cycles and generates all SRAM strobe timing from a programmable wait count.
- Returns read data and completion status through a single-cycle response pulse.

---
 rtl/sram_ctrl_if.sv | 22 ++
 rtl/sram_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - load/store request and response bus for the SRAM controller
interface sram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - sequences byte/half/word requests onto a 128K x 16 asynchronous SRAM
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    output logic        sram_cs1,
    output logic        sram_cs2,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        sram_lb,
    output logic        sram_ub,
    output logic [16:0] sram_a,
    inout  wire  [15:0] sram_io
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        phase;
    logic        we_r;
    logic [1:0]  size_r;
    logic [17:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rbuf;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        io_oe;
    logic [15:0] io_out;
    logic        misaligned;

    // Returns {ub, lb}, active low.
    function automatic logic [1:0] lane_mask(input logic [1:0] size, input logic a0);
        if (size == 2'b00)
            return a0 ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [15:0] phase_wdata(input logic [1:0] size, input logic [31:0] wd,
                                                input logic ph);
        if (size == 2'b00)
            return {wd[7:0], wd[7:0]};
        if (ph)
            return wd[31:16];
        return wd[15:0];
    endfunction

    always_comb begin
        misaligned = 1'b0;
        if (bus.req_size == 2'b01 && bus.req_addr[0])
            misaligned = 1'b1;
        if (bus.req_size[1] && bus.req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end

    assign sram_io        = io_oe ? io_out : 16'hzzzz;
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            phase        <= 1'b0;
            we_r         <= 1'b0;
            size_r       <= 2'b00;
            addr_r       <= 18'd0;
            wdata_r      <= 32'd0;
            rbuf         <= 32'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            sram_cs1     <= 1'b1;
            sram_cs2     <= 1'b0;
            sram_oe      <= 1'b1;
            sram_we      <= 1'b1;
            sram_lb      <= 1'b1;
            sram_ub      <= 1'b1;
            sram_a       <= 17'd0;
            io_oe        <= 1'b0;
            io_out       <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_r    <= bus.req_we;
                        size_r  <= bus.req_size;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        phase   <= 1'b0;
                        rbuf    <= 32'd0;
                        ready_q <= 1'b0;
                        if (misaligned) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            state              <= ACCESS;
                            cnt                <= CNT_LOAD;
                            sram_cs1           <= 1'b0;
                            sram_cs2           <= 1'b1;
                            sram_oe            <= bus.req_we;
                            sram_we            <= ~bus.req_we;
                            {sram_ub, sram_lb} <= lane_mask(bus.req_size, bus.req_addr[0]);
                            sram_a             <= bus.req_addr[17:1];
                            io_oe              <= bus.req_we;
                            io_out             <= phase_wdata(bus.req_size, bus.req_wdata, 1'b0);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state    <= HOLD;
                        sram_cs1 <= 1'b1;
                        sram_cs2 <= 1'b0;
                        sram_oe  <= 1'b1;
                        sram_we  <= 1'b1;
                        // Sample on the edge that closes the strobe window, before OE rises.
                        if (!we_r) begin
                            if (size_r == 2'b00)
                                rbuf[7:0] <= addr_r[0] ? sram_io[15:8] : sram_io[7:0];
                            else if (size_r[1] && phase)
                                rbuf[31:16] <= sram_io;
                            else
                                rbuf[15:0] <= sram_io;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (size_r[1] && !phase) begin
                        state    <= ACCESS;
                        phase    <= 1'b1;
                        cnt      <= CNT_LOAD;
                        sram_cs1 <= 1'b0;
                        sram_cs2 <= 1'b1;
                        sram_oe  <= we_r;
                        sram_we  <= ~we_r;
                        sram_a   <= addr_r[17:1] + 17'd1;
                        io_out   <= phase_wdata(size_r, wdata_r, 1'b1);
                    end else begin
                        state        <= RESP;
                        io_oe        <= 1'b0;
                        sram_lb      <= 1'b1;
                        sram_ub      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_r ? 32'd0 : rbuf;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
